// File: rtl/pll_seq_pkg.sv
// Shared state encoding and helpers for the PLL power-up / lock-supervision sequencer.
package pll_seq_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StPllReset = 3'd0,
        StWaitLock = 3'd1,
        StHold     = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } pll_state_e;

    // States in which the PLL is held in reset (RESETB driven low).
    function automatic logic holds_pll_reset(input pll_state_e st);
        return (st == StPllReset) || (st == StFault);
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to 0.
module sync_ff2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL RESETB, qualifies LOCK, and releases the system reset after stable lock plus
// a hold-off; retries failed lock attempts and latches a permanent fault.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned RST_HOLD_CYCLES    = 256,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned CNT_W              = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              pll_locked_i,
    input  logic              btn_reset_n_i,
    output logic              pll_resetb_o,
    output logic              sys_reset_n_o,
    output logic              ready_o,
    output logic              lock_lost_o,
    output logic              fault_o,
    output logic [1:0]        retry_count_o,
    output logic [StateW-1:0] state_o
);

    localparam logic [CNT_W-1:0] PllRstCnt     = CNT_W'(PLL_RST_CYCLES);
    localparam logic [CNT_W-1:0] LockStableCnt = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LockTimeoutCnt = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] RstHoldCnt    = CNT_W'(RST_HOLD_CYCLES);
    localparam logic [1:0]       MaxRetries    = 2'(MAX_RETRIES);

    logic lock_s;
    logic btn_s;

    sync_ff2 u_sync_lock (
        .clk_i  (clk_i),
        .rst_ni (reset_n_i),
        .d_i    (pll_locked_i),
        .q_o    (lock_s)
    );

    sync_ff2 u_sync_btn (
        .clk_i  (clk_i),
        .rst_ni (reset_n_i),
        .d_i    (btn_reset_n_i),
        .q_o    (btn_s)
    );

    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;          // PLL-reset length in PLL_RESET, hold-off in HOLD
    logic [CNT_W-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_inc, stable_inc, timeout_inc;
    logic [1:0]       retry_q, retry_d;
    logic             lock_lost_q, lock_lost_d;
    logic             pll_resetb_q, sys_reset_n_q, ready_q, fault_q;

    always_comb begin
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        stable_inc  = (stable_q == '1) ? stable_q : stable_q + 1'b1;
        timeout_inc = (timeout_q == '1) ? timeout_q : timeout_q + 1'b1;

        state_d     = state_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        timeout_d   = timeout_q;
        retry_d     = retry_q;
        lock_lost_d = lock_lost_q;

        unique case (state_q)
            StPllReset: begin
                cnt_d = cnt_inc;
                if (cnt_inc == PllRstCnt) begin
                    state_d   = StWaitLock;
                    stable_d  = '0;
                    timeout_d = '0;
                end
            end
            StWaitLock: begin
                stable_d  = lock_s ? stable_inc : '0;
                timeout_d = timeout_inc;
                // Stable completion outranks a coincident timeout.
                if (stable_d == LockStableCnt) begin
                    state_d = StHold;
                end else if (timeout_d == LockTimeoutCnt) begin
                    if (retry_q == MaxRetries) begin
                        state_d = StFault;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = StPllReset;
                    end
                end
            end
            StHold: begin
                cnt_d = btn_s ? cnt_inc : '0;
                if (!lock_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = StPllReset;
                end else if (cnt_d == RstHoldCnt) begin
                    retry_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!lock_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = StPllReset;
                end else if (!btn_s) begin
                    state_d = StHold;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StPllReset;
            end
        endcase

        // The shared counter restarts from zero in every newly entered state.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= StPllReset;
            cnt_q         <= '0;
            stable_q      <= '0;
            timeout_q     <= '0;
            retry_q       <= '0;
            lock_lost_q   <= 1'b0;
            pll_resetb_q  <= 1'b0;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            timeout_q     <= timeout_d;
            retry_q       <= retry_d;
            lock_lost_q   <= lock_lost_d;
            pll_resetb_q  <= !holds_pll_reset(state_d);
            sys_reset_n_q <= (state_d == StRun);
            ready_q       <= (state_d == StRun);
            fault_q       <= (state_d == StFault);
        end
    end

    assign pll_resetb_o  = pll_resetb_q;
    assign sys_reset_n_o = sys_reset_n_q;
    assign ready_o       = ready_q;
    assign lock_lost_o   = lock_lost_q;
    assign fault_o       = fault_q;
    assign retry_count_o = retry_q;
    assign state_o       = state_q;

endmodule
